rv32i_lsu: RTL and testbench

RV32I_LSU -- requirements
Module: rv32i_lsu

---
 rtl/be_pkg.sv | 62 ++++++
 rtl/rv32i_load_extend.sv | 33 +++
 rtl/rv32i_lsu.sv | 171 +++++++++++++++++
 tb/tb_rv32i_lsu.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/be_pkg.sv
// Shared types for the RV32I load/store unit: operand and mnemonic types,
// FSM state encoding, access sizes, byte-enable constants and decode helpers.
package be_pkg;

    typedef logic [31:0] RV32I_OPERAND_t;

    typedef enum logic [5:0] {
        LUI, AUIPC, JAL, JALR,
        BEQ, BNE, BLT, BGE, BLTU, BGEU,
        LB, LH, LW, LBU, LHU,
        SB, SH, SW,
        ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
        FENCE, ECALL, EBREAK
    } RV32I_INSTRUCTION_MNEMONIC_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } mem_size_t;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    function automatic logic is_mem_op(input RV32I_INSTRUCTION_MNEMONIC_t mn);
        return mn inside {LB, LH, LW, LBU, LHU, SB, SH, SW};
    endfunction

    function automatic logic is_load_op(input RV32I_INSTRUCTION_MNEMONIC_t mn);
        return mn inside {LB, LH, LW, LBU, LHU};
    endfunction

    function automatic logic is_unsigned_load(input RV32I_INSTRUCTION_MNEMONIC_t mn);
        return mn inside {LBU, LHU};
    endfunction

    function automatic mem_size_t mem_size(input RV32I_INSTRUCTION_MNEMONIC_t mn);
        case (mn)
            LB, LBU, SB: return SZ_BYTE;
            LH, LHU, SH: return SZ_HALF;
            default:     return SZ_WORD;
        endcase
    endfunction

    function automatic logic is_aligned(input mem_size_t size, input logic [1:0] offset);
        case (size)
            SZ_HALF: return ~offset[0];
            SZ_WORD: return (offset == 2'b00);
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_load_extend.sv
// Picks the addressed byte/halfword lane out of a read word and sign- or
// zero-extends it to a full operand.
module rv32i_load_extend
    import be_pkg::*;
(
    input  logic [31:0]    rdata,
    input  mem_size_t      size,
    input  logic           is_unsigned,
    input  logic [1:0]     offset,
    output RV32I_OPERAND_t data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = rdata[7:0];
        case (offset)
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            2'd3:    byte_lane = rdata[31:24];
            default: byte_lane = rdata[7:0];
        endcase
        half_lane = offset[1] ? rdata[31:16] : rdata[15:0];

        case (size)
            SZ_BYTE: data = {{24{~is_unsigned & byte_lane[7]}}, byte_lane};
            SZ_HALF: data = {{16{~is_unsigned & half_lane[15]}}, half_lane};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/rv32i_lsu.sv
// RV32I load/store unit: decodes a memory instruction, runs one bus access
// with a timeout, and returns the extended load result for write-back.
module rv32i_lsu
    import be_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
)
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        valid_i,
    input  RV32I_INSTRUCTION_MNEMONIC_t mnemonic,
    input  RV32I_OPERAND_t              addr,
    input  RV32I_OPERAND_t              store_data,
    output logic                        stall_o,
    output RV32I_OPERAND_t              load_data_o,
    output logic                        done_o,
    output logic                        misaligned_o,
    output logic                        bus_err_o,
    output logic                        mem_req,
    output logic                        mem_we,
    output logic [3:0]                  mem_be,
    output logic [31:0]                 mem_addr,
    output logic [31:0]                 mem_wdata,
    input  logic                        mem_gnt,
    input  logic                        mem_rvalid,
    input  logic [31:0]                 mem_rdata,
    output lsu_state_t                  state_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    lsu_state_t     state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic           timeout;

    mem_size_t      op_size;
    logic           op_unsigned;
    logic [1:0]     op_offset;
    logic           op_load;

    logic           mem_op;
    logic           ld_op;
    mem_size_t      size_in;
    logic           aligned;
    logic           launch;
    logic [3:0]     be_nxt;
    logic [31:0]    wdata_nxt;
    RV32I_OPERAND_t ext_data;

    // Instruction inputs only matter while IDLE; afterwards the op_* copies drive the access.
    always_comb begin
        mem_op       = is_mem_op(mnemonic);
        ld_op        = is_load_op(mnemonic);
        size_in      = mem_size(mnemonic);
        aligned      = is_aligned(size_in, addr[1:0]);
        launch       = (state == IDLE) && valid_i && mem_op && aligned;
        misaligned_o = (state == IDLE) && valid_i && mem_op && !aligned;
        stall_o      = launch || (state == REQ) || (state == WAIT);
        cnt_nxt      = cnt + CNT_W'(1);
        timeout      = (cnt_nxt == CNT_W'(TIMEOUT_CYCLES));
    end

    always_comb begin
        be_nxt    = BE_WORD;
        wdata_nxt = '0;
        if (!ld_op) begin
            case (size_in)
                SZ_BYTE: begin
                    be_nxt    = BE_BYTE << addr[1:0];
                    wdata_nxt = {4{store_data[7:0]}};
                end
                SZ_HALF: begin
                    be_nxt    = BE_HALF << addr[1:0];
                    wdata_nxt = {2{store_data[15:0]}};
                end
                default: begin
                    be_nxt    = BE_WORD;
                    wdata_nxt = store_data;
                end
            endcase
        end
    end

    rv32i_load_extend u_load_extend (
        .rdata       (mem_rdata),
        .size        (op_size),
        .is_unsigned (op_unsigned),
        .offset      (op_offset),
        .data        (ext_data)
    );

    // Bus handshake: mem_req rises with every field already valid and all of them
    // stay frozen until the cycle mem_gnt is seen in REQ; mem_rvalid counts only in WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_be      <= '0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            load_data_o <= '0;
            done_o      <= 1'b0;
            bus_err_o   <= 1'b0;
            op_size     <= SZ_BYTE;
            op_unsigned <= 1'b0;
            op_offset   <= '0;
            op_load     <= 1'b0;
        end else begin
            done_o    <= 1'b0;
            bus_err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (launch) begin
                        state       <= REQ;
                        cnt         <= '0;
                        mem_req     <= 1'b1;
                        mem_we      <= ~ld_op;
                        mem_be      <= be_nxt;
                        mem_addr    <= {addr[31:2], 2'b00};
                        mem_wdata   <= wdata_nxt;
                        op_size     <= size_in;
                        op_unsigned <= is_unsigned_load(mnemonic);
                        op_offset   <= addr[1:0];
                        op_load     <= ld_op;
                    end
                end
                REQ: begin
                    cnt <= cnt_nxt;
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        if (op_load) begin
                            state <= WAIT;
                        end else begin
                            state  <= DONE;
                            done_o <= 1'b1;
                        end
                    end else if (timeout) begin
                        state       <= DONE;
                        mem_req     <= 1'b0;
                        done_o      <= 1'b1;
                        bus_err_o   <= 1'b1;
                        load_data_o <= '0;
                    end
                end
                WAIT: begin
                    cnt <= cnt_nxt;
                    if (mem_rvalid) begin
                        state       <= DONE;
                        done_o      <= 1'b1;
                        load_data_o <= ext_data;
                    end else if (timeout) begin
                        state       <= DONE;
                        done_o      <= 1'b1;
                        bus_err_o   <= 1'b1;
                        load_data_o <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_rv32i_lsu.sv
// Directed and randomised load/store accesses against rv32i_lsu with a
// scoreboard of expected write-back results.
module tb_rv32i_lsu;
    import be_pkg::*;

    localparam int unsigned TO = 8;

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic                        valid_i;
    RV32I_INSTRUCTION_MNEMONIC_t mnemonic;
    RV32I_OPERAND_t              addr;
    RV32I_OPERAND_t              store_data;
    logic                        stall_o;
    RV32I_OPERAND_t              load_data_o;
    logic                        done_o;
    logic                        misaligned_o;
    logic                        bus_err_o;
    logic                        mem_req;
    logic                        mem_we;
    logic [3:0]                  mem_be;
    logic [31:0]                 mem_addr;
    logic [31:0]                 mem_wdata;
    logic                        mem_gnt;
    logic                        mem_rvalid;
    logic [31:0]                 mem_rdata;
    lsu_state_t                  state_o;

    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q[$];
    logic [31:0] model_ld = '0;

    RV32I_INSTRUCTION_MNEMONIC_t ops[8] = '{LB, LH, LW, LBU, LHU, SB, SH, SW};

    always #5 clk = ~clk;

    rv32i_lsu #(.TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_i      (valid_i),
        .mnemonic     (mnemonic),
        .addr         (addr),
        .store_data   (store_data),
        .stall_o      (stall_o),
        .load_data_o  (load_data_o),
        .done_o       (done_o),
        .misaligned_o (misaligned_o),
        .bus_err_o    (bus_err_o),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_be       (mem_be),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_gnt      (mem_gnt),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .state_o      (state_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic is_ld(input RV32I_INSTRUCTION_MNEMONIC_t mn);
        return (mn == LB) || (mn == LH) || (mn == LW) || (mn == LBU) || (mn == LHU);
    endfunction

    function automatic logic [31:0] model_load(input RV32I_INSTRUCTION_MNEMONIC_t mn,
                                               input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] sh;
        sh = rd >> (8 * a[1:0]);
        case (mn)
            LB:      return {{24{sh[7]}}, sh[7:0]};
            LBU:     return {24'h0, sh[7:0]};
            LH:      return {{16{sh[15]}}, sh[15:0]};
            LHU:     return {16'h0, sh[15:0]};
            default: return rd;
        endcase
    endfunction

    function automatic logic [3:0] model_be(input RV32I_INSTRUCTION_MNEMONIC_t mn, input logic [31:0] a);
        logic [3:0] b;
        b = 4'hF;
        if (mn == SB) b = 4'b0001 << a[1:0];
        if (mn == SH) b = 4'b0011 << a[1:0];
        return b;
    endfunction

    function automatic logic [31:0] model_wdata(input RV32I_INSTRUCTION_MNEMONIC_t mn, input logic [31:0] sd);
        if (mn == SB) return {sd[7:0], sd[7:0], sd[7:0], sd[7:0]};
        if (mn == SH) return {sd[15:0], sd[15:0]};
        return sd;
    endfunction

    // One complete access from IDLE: acts as the memory, checks the bus fields every
    // request cycle, and checks latency and the write-back result when done_o shows up.
    task automatic access(input RV32I_INSTRUCTION_MNEMONIC_t mn, input logic [31:0] a,
                          input logic [31:0] sd, input logic [31:0] rd,
                          input int gnt_dly, input int rv_dly,
                          input logic [31:0] e_addr, input logic [3:0] e_be,
                          input logic [31:0] e_wdata, output int bus_cycles);
        int req_n, wait_n, stalls, done_at, exp_at;
        bit granted, seen, ld, to_exp;
        logic [32:0] e;
        ld      = is_ld(mn);
        to_exp  = (gnt_dly + 1 > TO) || (ld && (rv_dly < 0 || gnt_dly + rv_dly + 2 > TO));
        exp_at  = to_exp ? TO + 1 : (ld ? gnt_dly + rv_dly + 3 : gnt_dly + 2);
        if (to_exp) model_ld = '0;
        else if (ld) model_ld = model_load(mn, a, rd);
        exp_q.push_back({to_exp, model_ld});

        valid_i = 1'b1; mnemonic = mn; addr = a; store_data = sd;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
        req_n = 0; wait_n = 0; granted = 0; seen = 0; stalls = 0; done_at = -1; bus_cycles = 0;
        #1;
        check("misaligned_clear", 32'(misaligned_o), 32'd0);
        for (int c = 0; c < int'(TO) + 8; c++) begin
            if (done_o) begin
                seen = 1; done_at = c;
                break;
            end
            if (stall_o) stalls++;
            if (mem_req) begin
                bus_cycles++;
                check("bus_addr", mem_addr, e_addr);
                check("bus_be", 32'(mem_be), 32'(e_be));
                check("bus_we", 32'(mem_we), 32'(!ld));
                if (!ld) check("bus_wdata", mem_wdata, e_wdata);
            end
            @(negedge clk);
            valid_i = 1'b0; mnemonic = ADDI; addr = $urandom; store_data = $urandom;
            if (mem_req && !granted) begin
                mem_gnt    = (req_n == gnt_dly);
                granted    = mem_gnt;
                req_n++;
                mem_rvalid = 1'($urandom_range(0, 1));
                mem_rdata  = $urandom;
            end else if (granted) begin
                mem_gnt    = 1'($urandom_range(0, 1));
                mem_rvalid = (rv_dly >= 0) && (wait_n == rv_dly);
                mem_rdata  = mem_rvalid ? rd : $urandom;
                wait_n++;
            end else begin
                mem_gnt = 1'b0; mem_rvalid = 1'b0;
            end
            #1;
        end
        check("done_seen", 32'(seen), 32'd1);
        e = exp_q.pop_front();
        check("done_latency", 32'(done_at), 32'(exp_at));
        check("stall_cycles", 32'(stalls), 32'(exp_at));
        check("done_stall", 32'(stall_o), 32'd0);
        check("done_req", 32'(mem_req), 32'd0);
        check("load_data", load_data_o, e[31:0]);
        check("bus_err", 32'(bus_err_o), 32'(e[32]));
        @(negedge clk);
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        #1;
        check("idle_after_done", 32'(state_o), 32'(IDLE));
        check("done_one_cycle", 32'(done_o), 32'd0);
        check("bus_err_one_cycle", 32'(bus_err_o), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_state"}, 32'(state_o), 32'(IDLE));
        check({tag, "_req"}, 32'(mem_req), 32'd0);
        check({tag, "_we"}, 32'(mem_we), 32'd0);
        check({tag, "_be"}, 32'(mem_be), 32'd0);
        check({tag, "_addr"}, mem_addr, 32'd0);
        check({tag, "_wdata"}, mem_wdata, 32'd0);
        check({tag, "_ld"}, load_data_o, 32'd0);
        check({tag, "_done"}, 32'(done_o), 32'd0);
        check({tag, "_err"}, 32'(bus_err_o), 32'd0);
        check({tag, "_stall"}, 32'(stall_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int bc;
        RV32I_INSTRUCTION_MNEMONIC_t mn;
        logic [31:0] a, sd, rd;
        RV32I_INSTRUCTION_MNEMONIC_t bad_mn[3] = '{LW, SH, LH};
        logic [31:0] bad_a[3] = '{32'h0000_3001, 32'h0000_2003, 32'h0000_7005};

        // clock/reset
        rst_n = 1'b1; valid_i = 1'b0; mnemonic = ADD; addr = '0; store_data = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // non-memory op never stalls
        valid_i = 1'b1; mnemonic = ADD; addr = 32'h0000_1001;
        #1;
        check("nonmem_stall", 32'(stall_o), 32'd0);
        check("nonmem_misaligned", 32'(misaligned_o), 32'd0);
        @(negedge clk);
        #1;
        check("nonmem_state", 32'(state_o), 32'(IDLE));
        check("nonmem_req", 32'(mem_req), 32'd0);
        valid_i = 1'b0;

        // LB sign extension with immediate grant and read data
        access(LB, 32'h0000_1003, 32'h0, 32'h80FF_FF7F, 0, 0, 32'h0000_1000, 4'hF, 32'h0, bc);
        check("lb_vector", load_data_o, 32'hFFFF_FF80);

        // SH to upper halfword
        access(SH, 32'h0000_2002, 32'h1234_ABCD, 32'h0, 0, 0, 32'h0000_2000, 4'b1100, 32'hABCD_ABCD, bc);
        check("sh_bus_cycles", 32'(bc), 32'd1);

        // misaligned ops: flagged combinationally, no bus request
        for (int i = 0; i < 3; i++) begin
            valid_i = 1'b1; mnemonic = bad_mn[i]; addr = bad_a[i];
            #1;
            check("misaligned_flag", 32'(misaligned_o), 32'd1);
            check("misaligned_stall", 32'(stall_o), 32'd0);
            repeat (2) begin
                @(negedge clk);
                #1;
                check("misaligned_req", 32'(mem_req), 32'd0);
                check("misaligned_state", 32'(state_o), 32'(IDLE));
            end
        end
        valid_i = 1'b0;
        #1;
        check("misaligned_drop", 32'(misaligned_o), 32'd0);

        // SW with grant withheld five cycles
        access(SW, 32'h0000_5008, 32'hDEAD_BEEF, 32'h0, 5, 0, 32'h0000_5008, 4'hF, 32'hDEAD_BEEF, bc);
        check("sw_stable_cycles", 32'(bc), 32'd6);

        // LHU whose read data never returns
        access(LHU, 32'h0000_6002, 32'h0, 32'h0, 0, -1, 32'h0000_6000, 4'hF, 32'h0, bc);
        check("lhu_timeout_ld", load_data_o, 32'd0);

        // store never granted
        access(SB, 32'h0000_7001, 32'h0000_00A5, 32'h0, 20, 0, 32'h0000_7000, 4'b0010, 32'hA5A5_A5A5, bc);
        check("sb_timeout_cycles", 32'(bc), 32'(TO));

        // timeout boundary: last allowed cycle succeeds, one later aborts
        access(LH, 32'h0000_8002, 32'h0, 32'h9ABC_1234, 3, 3, 32'h0000_8000, 4'hF, 32'h0, bc);
        access(LBU, 32'h0000_8001, 32'h0, 32'h9ABC_F234, 3, 4, 32'h0000_8000, 4'hF, 32'h0, bc);

        // randomised aligned accesses
        for (int i = 0; i < 16; i++) begin
            mn = ops[$urandom_range(0, 7)];
            a  = $urandom_range(0, 32'hFFFF);
            if (mem_size(mn) == SZ_HALF) a[0] = 1'b0;
            if (mem_size(mn) == SZ_WORD) a[1:0] = 2'b00;
            sd = $urandom;
            rd = $urandom;
            access(mn, a, sd, rd, $urandom_range(0, 2), $urandom_range(0, 2),
                   {a[31:2], 2'b00}, model_be(mn, a), model_wdata(mn, sd), bc);
        end

        // reset while waiting for read data
        access(LW, 32'h0000_4000, 32'h0, 32'hCAFE_F00D, 0, 0, 32'h0000_4000, 4'hF, 32'h0, bc);
        valid_i = 1'b1; mnemonic = LW; addr = 32'h0000_4004;
        @(negedge clk);
        valid_i = 1'b0; mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        #1;
        check("pre_reset_state", 32'(state_o), 32'(WAIT));
        check("pre_reset_ld", load_data_o, 32'hCAFE_F00D);
        #1 rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        model_ld = '0;
        @(negedge clk);
        rst_n = 1'b1; mem_rvalid = 1'b1; mem_gnt = 1'b1; mem_rdata = 32'h1234_5678;
        repeat (3) begin
            @(negedge clk);
            #1;
            check("late_rvalid_ld", load_data_o, 32'd0);
            check("late_rvalid_done", 32'(done_o), 32'd0);
            check("late_rvalid_state", 32'(state_o), 32'(IDLE));
        end
        mem_rvalid = 1'b0; mem_gnt = 1'b0;

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
